drbg_keystream_serializer: RTL and testbench

Consumes 256-bit words from the hash DRBG via its `next_bits` / `next_bits_ready` handshake and re-emits them as a stream of narrow per-pixel key slices with valid/ready flow control. It sits between the DRBG and the pixel scrambler. It keeps a 2-word prefetch buffer so that a full word is normally available while the next one is being generated.

---
 rtl/drbg_keystream_serializer_pkg.sv | 11 +
 rtl/drbg_keystream_serializer_if.sv | 27 ++
 rtl/drbg_keystream_serializer_word_buffer.sv | 40 ++++
 rtl/drbg_keystream_serializer.sv | 80 ++++++++
 tb/tb_drbg_keystream_serializer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/drbg_keystream_serializer_pkg.sv
// drbg_keystream_pkg: shared widths, fetch-state encodings and slice-count helper
// Exports WORD_WIDTH (DRBG word), KEY_WIDTH_DEFAULT, SLICES and fetch_state_t.
package drbg_keystream_pkg;
    localparam int WORD_WIDTH = 256;
    localparam int KEY_WIDTH_DEFAULT = 8;
    localparam int SLICES = WORD_WIDTH / KEY_WIDTH_DEFAULT;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_RELEASE} fetch_state_t;
    function automatic int slices_of(input int kw);
        return WORD_WIDTH / kw;
    endfunction
endpackage

// File: rtl/drbg_keystream_serializer_if.sv
// drbg_keystream_serializer_if: DRBG request handshake plus key-slice stream
// master: serializer side (drives next_bits, key_data, key_valid, underrun, words_consumed)
// slave : DRBG/consumer side (drives init_ready, next_bits_ready, random_bits, flush, key_ready)
interface drbg_keystream_serializer_if
    import drbg_keystream_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT
) ();
    logic                  init_ready;
    logic                  next_bits;
    logic                  next_bits_ready;
    logic [WORD_WIDTH-1:0] random_bits;
    logic                  flush;
    logic [KEY_WIDTH-1:0]  key_data;
    logic                  key_valid;
    logic                  key_ready;
    logic                  underrun;
    logic [31:0]           words_consumed;
    modport master (
        input  init_ready, next_bits_ready, random_bits, flush, key_ready,
        output next_bits, key_data, key_valid, underrun, words_consumed
    );
    modport slave (
        output init_ready, next_bits_ready, random_bits, flush, key_ready,
        input  next_bits, key_data, key_valid, underrun, words_consumed
    );
endinterface

// File: rtl/drbg_keystream_serializer_word_buffer.sv
// keystream_word_buffer: 2-entry DRBG word store with write/read pointers and occupancy
// Ports: clk, reset, flush (clears pointers/count only), wr_en/wr_data (capture),
//        pop (drop head word), rd_data (head word), count (0..2)
module keystream_word_buffer
    import drbg_keystream_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [1:0]            count
);
    logic [WORD_WIDTH-1:0] mem [2];
    logic                  wp;
    logic                  rp;
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) mem[wp] <= wr_data;
            if (flush) begin
                wp    <= 1'b0;
                rp    <= 1'b0;
                count <= 2'd0;
            end else begin
                wp    <= wp ^ wr_en;
                rp    <= rp ^ pop;
                count <= count + {1'b0, wr_en} - {1'b0, pop};
            end
        end
    end
    assign rd_data = mem[rp];
endmodule

// File: rtl/drbg_keystream_serializer.sv
// drbg_keystream_serializer: fetches DRBG words into a 2-word buffer and streams them as key slices
// Ports: clk, reset (sync, active-high), bus (drbg_keystream_serializer_if.master):
//        DRBG request handshake, flush pulse, LSB-first key slice stream, underrun flag, word counter
module drbg_keystream_serializer
    import drbg_keystream_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT
) (
    input logic clk,
    input logic reset,
    drbg_keystream_serializer_if.master bus
);
    localparam int NS = slices_of(KEY_WIDTH);
    localparam int SW = $clog2(NS);
    localparam logic [SW-1:0] SI_LAST = SW'(NS - 1);
    fetch_state_t                 state;
    logic [SW-1:0]                si;
    logic [1:0]                   count;
    logic [WORD_WIDTH-1:0]        rd_data;
    logic [NS-1:0][KEY_WIDTH-1:0] slices;
    logic                         has_room;
    logic                         capture;
    logic                         accept;
    logic                         pop;
    assign has_room = count != 2'd2;
    // flush discards the in-flight word and any accept in the same cycle
    assign capture  = state == F_REQ && bus.next_bits_ready && !bus.flush;
    assign accept   = bus.key_valid && bus.key_ready && !bus.flush;
    assign pop      = accept && si == SI_LAST;
    assign slices   = rd_data;
    assign bus.key_valid = count != 2'd0;
    assign bus.key_data  = slices[si];
    keystream_word_buffer u_buf (
        .clk    (clk),
        .reset  (reset),
        .flush  (bus.flush),
        .wr_en  (capture),
        .wr_data(bus.random_bits),
        .pop    (pop),
        .rd_data(rd_data),
        .count  (count)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= F_IDLE;
            bus.next_bits <= 1'b0;
        end else begin
            case (state)
                F_IDLE: if (bus.init_ready && has_room && !bus.flush) begin
                    state         <= F_REQ;
                    bus.next_bits <= 1'b1;
                end
                F_REQ: if (bus.flush || bus.next_bits_ready) begin
                    state         <= F_RELEASE;
                    bus.next_bits <= 1'b0;
                end
                // hold off until the DRBG withdraws its ready so one word is never taken twice
                F_RELEASE: if (!bus.next_bits_ready) begin
                    state         <= (bus.init_ready && has_room) ? F_REQ : F_IDLE;
                    bus.next_bits <= bus.init_ready && has_room;
                end
                default: begin
                    state         <= F_IDLE;
                    bus.next_bits <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            si                 <= '0;
            bus.underrun       <= 1'b0;
            bus.words_consumed <= 32'd0;
        end else begin
            si                 <= (bus.flush || pop) ? '0 : accept ? si + 1'b1 : si;
            bus.underrun       <= !bus.flush && (bus.underrun || (bus.key_ready && !bus.key_valid));
            bus.words_consumed <= bus.words_consumed + 32'(pop);
        end
    end
endmodule

// File: tb/tb_drbg_keystream_serializer.sv
// tb_drbg_keystream_serializer: scoreboard bench with a DRBG stub and directed key_ready patterns
module tb_drbg_keystream_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    drbg_keystream_serializer_if bus ();
    drbg_keystream_serializer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    int beats = 0;
    int delay = 3;
    int cnt = 0;
    int wn = 0;
    int raises = 0;
    bit manual = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] mkword(input int n);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(n * 32 + i);
        return w;
    endfunction

    task automatic push_word(input logic [255:0] w);
        for (int i = 0; i < 32; i++) exp_q.push_back(w[i*8 +: 8]);
    endtask

    // DRBG stub: replies `delay` cycles after the request, holds ready until next_bits drops
    always @(posedge clk) begin
        #2;
        if (!manual) begin
            if (reset) begin
                bus.next_bits_ready = 1'b0;
                cnt = 0;
            end else if (bus.next_bits_ready) begin
                if (!bus.next_bits) bus.next_bits_ready = 1'b0;
            end else if (bus.next_bits) begin
                cnt++;
                if (cnt >= delay) begin
                    bus.random_bits = mkword(wn);
                    push_word(bus.random_bits);
                    wn++;
                    raises++;
                    cnt = 0;
                    bus.next_bits_ready = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // monitor: every accepted slice must be the next expected byte
    always @(negedge clk) begin
        if (reset || bus.flush) begin
            exp_q.delete();
        end else if (bus.key_valid && bus.key_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL key_unexpected: got %0h expected none at %0t", bus.key_data, $time);
            end else begin
                exp_b = exp_q.pop_front();
                chk("key_data", 32'(bus.key_data), 32'(exp_b));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.init_ready = 1'b0;
        bus.key_ready = 1'b0;
        bus.flush = 1'b0;
        manual = 1'b0;
        delay = 3;
        wn = 0;
        raises = 0;
        beats = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 300 && !bus.key_valid; i++) @(negedge clk);
        chk(name, 32'(bus.key_valid), 32'd1);
    endtask

    initial begin
        int gaps;
        bus.init_ready = 1'b0;
        bus.next_bits_ready = 1'b0;
        bus.random_bits = '0;
        bus.flush = 1'b0;
        bus.key_ready = 1'b0;

        // reset state, then streaming word0 at full rate
        do_reset();
        @(negedge clk);
        chk("rst_next_bits", 32'(bus.next_bits), 32'd0);
        chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
        chk("rst_key_data", 32'(bus.key_data), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_words_consumed", bus.words_consumed, 32'd0);
        bus.init_ready = 1'b1;
        bus.key_ready = 1'b1;
        wait_valid("t1_valid_rise");
        gaps = 0;
        for (int i = 0; i < 32; i++) begin
            if (!bus.key_valid) gaps++;
            @(negedge clk);
        end
        chk("t1_valid_gaps", 32'(gaps), 32'd0);
        chk("t1_words_consumed", bus.words_consumed, 32'd1);

        // no consumer: buffer fills with exactly two words and fetching stops
        do_reset();
        bus.init_ready = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t2_captures", 32'(raises), 32'd2);
        chk("t2_next_bits", 32'(bus.next_bits), 32'd0);
        chk("t2_key_valid", 32'(bus.key_valid), 32'd1);
        chk("t2_key_data", 32'(bus.key_data), 32'h00);
        chk("t2_underrun", 32'(bus.underrun), 32'd0);

        // toggling consumer across word boundaries
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            bus.key_ready = (i % 2 == 0);
        end
        @(posedge clk); #1;
        bus.key_ready = 1'b0;
        @(negedge clk);
        chk("t3_beats", 32'(beats), 32'd100);
        chk("t3_words_consumed", bus.words_consumed, 32'd3);

        // slow DRBG: underrun sets, sticks, and flush clears it (flush wins)
        do_reset();
        delay = 100;
        bus.init_ready = 1'b1;
        bus.key_ready = 1'b1;
        @(negedge clk);
        chk("t4_underrun_pre", 32'(bus.underrun), 32'd0);
        @(negedge clk);
        chk("t4_underrun_set", 32'(bus.underrun), 32'd1);
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("t4_underrun_sticky", 32'(bus.underrun), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.key_ready = 1'b0;
        @(negedge clk);
        chk("t4_underrun_flush", 32'(bus.underrun), 32'd0);
        chk("t4_valid_flush", 32'(bus.key_valid), 32'd0);
        chk("t4_wc_kept", bus.words_consumed, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_underrun_stays", 32'(bus.underrun), 32'd0);

        // flush during an outstanding request with one word buffered
        do_reset();
        bus.init_ready = 1'b1;
        @(negedge clk);
        wait_valid("t5_first_word");
        delay = 1000;
        for (int i = 0; i < 20 && !bus.next_bits; i++) @(negedge clk);
        chk("t5_req_pending", 32'(bus.next_bits), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("t5_next_bits_drop", 32'(bus.next_bits), 32'd0);
        chk("t5_valid_flush", 32'(bus.key_valid), 32'd0);
        @(negedge clk);
        chk("t5_rerequest", 32'(bus.next_bits), 32'd1);
        delay = 3;
        bus.key_ready = 1'b1;
        wait_valid("t5_new_word");
        chk("t5_first_key", 32'(bus.key_data), 32'h20);
        repeat (10) @(posedge clk);
        #1 bus.key_ready = 1'b0;

        // capture lands on the last-slice accept of the other entry
        do_reset();
        bus.init_ready = 1'b1;
        @(negedge clk);
        wait_valid("t6_first_word");
        delay = 1000;
        for (int i = 0; i < 20 && !bus.next_bits; i++) @(negedge clk);
        chk("t6_req_pending", 32'(bus.next_bits), 32'd1);
        @(posedge clk); #1;
        bus.key_ready = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        manual = 1'b1;
        bus.random_bits = mkword(5);
        push_word(bus.random_bits);
        bus.next_bits_ready = 1'b1;
        @(posedge clk); #1;
        bus.next_bits_ready = 1'b0;
        manual = 1'b0;
        delay = 3;
        @(negedge clk);
        chk("t6_valid_kept", 32'(bus.key_valid), 32'd1);
        chk("t6_first_key", 32'(bus.key_data), 32'hA0);
        chk("t6_words_consumed", bus.words_consumed, 32'd1);
        @(negedge clk);
        chk("t6_count_one_rereq", 32'(bus.next_bits), 32'd1);
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.key_valid) gaps++;
            @(negedge clk);
        end
        chk("t6_valid_gaps", 32'(gaps), 32'd0);
        @(posedge clk); #1;
        bus.key_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end
endmodule
